// File: rtl/updown_counter_param.sv
// ---------------------------------------------------------------------------
// updown_counter_param
//
// Loadable up/down modulo counter with programmable step, count enable,
// registered wrap pulse and combinational terminal-count flag.
//
// Optional feature macro: COUNTER_SAT_EN
//   defined   -> sat input selects saturation at 0 / MODULUS-1
//   undefined -> sat is unused and the counter always wraps
//
// Parameters
//   WIDTH    counter/data width in bits (2..32)
//   MODULUS  count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//
// Ports
//   clk       clock, all state updates on rising edge
//   rst       asynchronous active-low reset
//   en        count enable (ignored while load=1)
//   load      synchronous load of data (highest priority)
//   updown    1 = count up, 0 = count down
//   step      amount added/subtracted per enabled cycle
//   sat       1 = saturate instead of wrap (COUNTER_SAT_EN builds only)
//   data      load value
//   data_out  registered count
//   wrap      registered one-cycle pulse: last update wrapped
//   tc        terminal count: MODULUS-1 when counting up, 0 when down
// ---------------------------------------------------------------------------
module updown_counter_param #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic             updown,
   input  logic [WIDTH-1:0] step,
   input  logic             sat,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] data_out,
   output logic             wrap,
   output logic             tc
);

   // All range arithmetic is done one bit wider so MODULUS == 2**WIDTH
   // and the up-count sum both fit without overflow.
   localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0]   MAX_W = MOD_W - 1'b1;
   localparam logic [WIDTH-1:0] MAX_V = MAX_W[WIDTH-1:0];

   logic [WIDTH:0]   step_w;
   logic [WIDTH:0]   s_eff;
   logic [WIDTH:0]   cnt_w;
   logic [WIDTH:0]   sum_up;
   logic [WIDTH:0]   sum_dn_wrap;
   logic             sat_mode;
   logic [WIDTH-1:0] next_cnt;
   logic             next_wrap;

`ifdef COUNTER_SAT_EN
   assign sat_mode = sat;
`else
   logic unused_sat;
   assign unused_sat = sat;
   assign sat_mode   = 1'b0;
`endif

   assign step_w      = {1'b0, step};
   assign s_eff       = (step_w >= MOD_W) ? MAX_W : step_w;
   assign cnt_w       = {1'b0, data_out};
   assign sum_up      = cnt_w + s_eff;
   // Only used when data_out < s, so the result lies in 1..MODULUS-1.
   assign sum_dn_wrap = cnt_w + MOD_W - s_eff;

   always_comb begin
      next_cnt  = data_out;
      next_wrap = 1'b0;
      if (load) begin
         next_cnt = ({1'b0, data} >= MOD_W) ? MAX_V : data;
      end else if (en) begin
         if (updown) begin
            if (sum_up < MOD_W) begin
               next_cnt = sum_up[WIDTH-1:0];
            end else if (sat_mode) begin
               next_cnt = MAX_V;
            end else begin
               next_cnt  = WIDTH'(sum_up - MOD_W);
               next_wrap = 1'b1;
            end
         end else begin
            if (cnt_w >= s_eff) begin
               next_cnt = WIDTH'(cnt_w - s_eff);
            end else if (sat_mode) begin
               next_cnt = '0;
            end else begin
               next_cnt  = sum_dn_wrap[WIDTH-1:0];
               next_wrap = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out <= '0;
         wrap     <= 1'b0;
      end else begin
         data_out <= next_cnt;
         wrap     <= next_wrap;
      end
   end

   assign tc = updown ? (data_out == MAX_V) : (data_out == '0);

endmodule

// File: doc/updown_counter_param.md
# updown_counter_param

Parametrised loadable up/down counter: the next generation of the 4-bit load/updown/data counter the bench drives through its BFM and monitor clocking blocks. It adds:
- configurable width and modulus
- programmable step size
- a count enable
- a registered wrap pulse and a terminal-count flag
- optional compile-in saturation

It is the DUT for the next counter verification environment. Its load/updown/data/data_out signal set stays compatible with the existing interface style.

## Interface
- WIDTH, 4, counter and data width in bits; 2..32.
- MODULUS, 10, count range is 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH.
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  reset. Asynchronous, active-low: asserting it (0) clears state immediately; deassertion is sampled on posedge clk.
- en  input  1  count enable; ignored while load=1.
- load  input  1  synchronous load of data.
- updown  input  1  1 = count up, 0 = count down.
- step  input  WIDTH  increment/decrement amount per enabled cycle.
- sat  input  1  1 = saturate at the range limits instead of wrapping. Honoured only when COUNTER_SAT_EN is defined.
- data  input  WIDTH  load value.
- data_out  output  WIDTH  registered count.
- wrap  output  1  registered one-cycle pulse: the last update wrapped around the modulus.
- tc  output  1  combinational terminal count: data_out == MODULUS-1 when updown=1, data_out == 0 when updown=0.

## Operation
- Reset (rst=0): data_out=0, wrap=0. tc then follows its combinational definition (1 if updown=0).
- Priority at each posedge with rst=1: load, then en, then hold.
- **load=1:** data_out <= (data >= MODULUS) ? MODULUS-1 : data. wrap <= 0. en, updown and step are ignored.
- **Step clamping:** the effective step s = (step >= MODULUS) ? MODULUS-1 : step.
- **en=1, updown=1:** compute n = data_out + s in WIDTH+1 bits.
  - If n < MODULUS: data_out <= n, wrap <= 0.
  - Otherwise, wrap mode: data_out <= n - MODULUS, wrap <= 1.
  - Otherwise, saturate mode: data_out <= MODULUS-1, wrap <= 0.
- **en=1, updown=0:**
  - If data_out >= s: data_out <= data_out - s, wrap <= 0.
  - Otherwise, wrap mode: data_out <= data_out + MODULUS - s, wrap <= 1.
  - Otherwise, saturate mode: data_out <= 0, wrap <= 0.
- **s=0 with en=1:** data_out holds, wrap <= 0.
- **en=0, load=0:** data_out holds, wrap <= 0. wrap is therefore never high for two consecutive cycles unless two consecutive wrapping steps occur.
- **Mode selection:** saturate mode applies only when COUNTER_SAT_EN is defined and sat=1. Otherwise wrap mode applies.
- **Range:** data_out is always in 0..MODULUS-1 after reset or any update.

## Timing
- Inputs are sampled at posedge clk. The bench drives them with an output skew of #1 after the edge.
- data_out and wrap are valid one clock after the sampled inputs; latency is 1 cycle for load and for count.
- tc is combinational from data_out and updown; it changes in the same cycle updown changes.
- Reset mid-operation: asserting rst between edges forces data_out=0 and wrap=0 without waiting for clk. The first update after release occurs on the first posedge with rst=1.
- Simultaneous load and en: load wins, no count occurs that cycle.

## Configuration
- COUNTER_SAT_EN
  - **Defined:** sat input is honoured and saturate mode clamps at 0 / MODULUS-1 as above.
  - **Undefined:** sat is ignored (port kept, unused) and the counter always wraps. The saturation comparators are not built.

## Test plan
WIDTH=4, MODULUS=10 throughout.
- **Async reset mid-count:** count up step 1 from 0 to 5, drive rst=0 mid-cycle -> data_out=0 and wrap=0 before the next posedge. Release -> next enabled up step gives 1.
- **Up wrap:** load 8, then en=1, updown=1, step=3 -> data_out 1 with wrap=1 for one cycle. Next cycle -> 4, wrap=0.
- **Down wrap:** load 1, then en=1, updown=0, step=2 -> data_out 9, wrap=1. With updown=1 held afterwards, tc=1.
- **Load clamp and priority:** load=1, en=1, data=15, step=1 -> data_out 9, wrap=0, tc=1 (updown=1).
- **Step clamp and hold:**
  - step=12 from 0, up -> 9.
  - step=0, en=1 -> value holds, wrap=0.
  - en=0 -> value holds.
- **Saturation (COUNTER_SAT_EN defined):**
  - sat=1, from 8 up step 3 -> 9, wrap=0, and stays 9.
  - sat=1, from 1 down step 2 -> 0.
  - Same stimulus with the macro undefined -> 1 with wrap=1 (up case).
